// File: rtl/mem2_load_align.sv
// rtl/mem2_load_align.sv - Mem2 load response: SRAM word capture, byte alignment/extension, skid-buffered writeback result
module mem2_load_align #(
  parameter int CACHE_WIDTHE = 6,
  parameter int CACHE_DEEPTHE = 6,
  localparam int DW = 2**CACHE_WIDTHE,
  localparam int OW = CACHE_WIDTHE - 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iReqValid,
  input  logic [OW-1:0] iReqOffset,
  input  logic [1:0]    iReqSize,
  input  logic          iReqUnsigned,
  input  logic [4:0]    iReqRd,
  input  logic [DW-1:0] iSramRdData,
  input  logic          iStall,
  input  logic          iFlush,
  output logic          oReqReady,
  output logic          oValid,
  output logic [DW-1:0] oRdData,
  output logic [4:0]    oRd,
  output logic          oMisalign
);

  if (CACHE_WIDTHE != 6 || CACHE_DEEPTHE < 1) begin : g_param_check
    $error("mem2_load_align: only 64-bit data words with a non-empty SRAM are supported");
  end

  typedef enum logic [1:0] {IDLE, DATA, HOLD} state_t;

  state_t        state, state_nxt;
  logic          acc, load_out, load_skid;

  logic [OW-1:0] m_off;
  logic [1:0]    m_size;
  logic          m_uns;
  logic [4:0]    m_rd;

  logic [DW-1:0] skid_data;
  logic [4:0]    skid_rd;
  logic          skid_mis;

  logic [DW-1:0] sh, mask, al_data;
  logic          sgn, al_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (iFlush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = acc ? DATA : IDLE;
        DATA: begin
          if (!oValid || !iStall) state_nxt = acc ? DATA : IDLE;
          else                    state_nxt = HOLD;
        end
        HOLD: state_nxt = iStall ? HOLD : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The SRAM word is only valid in DATA, so ready must drop whenever it could not be stored.
  always_comb begin
    oReqReady = (state != HOLD) && !(state == DATA && oValid && iStall);
    acc       = iReqValid && oReqReady && !iFlush;
    load_out  = (state == DATA && (!oValid || !iStall)) || (state == HOLD && !iStall);
    load_skid = (state == DATA) && oValid && iStall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_off  <= '0;
      m_size <= '0;
      m_uns  <= 1'b0;
      m_rd   <= '0;
    end else if (acc) begin
      m_off  <= iReqOffset;
      m_size <= iReqSize;
      m_uns  <= iReqUnsigned;
      m_rd   <= iReqRd;
    end
  end

  always_comb begin
    sh = iSramRdData >> {m_off, 3'b000};
    case (m_size)
      2'd0: begin
        mask   = {{(DW-8){1'b0}}, {8{1'b1}}};
        sgn    = sh[7];
        al_mis = 1'b0;
      end
      2'd1: begin
        mask   = {{(DW-16){1'b0}}, {16{1'b1}}};
        sgn    = sh[15];
        al_mis = m_off[0];
      end
      2'd2: begin
        mask   = {{(DW-32){1'b0}}, {32{1'b1}}};
        sgn    = sh[31];
        al_mis = |m_off[1:0];
      end
      default: begin
        mask   = '1;
        sgn    = 1'b0;
        al_mis = |m_off[2:0];
      end
    endcase
    al_data = sh & mask;
    if (!m_uns && sgn) al_data = al_data | ~mask;
    if (al_mis)        al_data = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
      skid_rd   <= '0;
      skid_mis  <= 1'b0;
    end else if (load_skid && !iFlush) begin
      skid_data <= al_data;
      skid_rd   <= m_rd;
      skid_mis  <= al_mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid    <= 1'b0;
      oRdData   <= '0;
      oRd       <= '0;
      oMisalign <= 1'b0;
    end else if (iFlush) begin
      oValid <= 1'b0;
    end else if (load_out) begin
      oValid <= 1'b1;
      if (state == HOLD) begin
        oRdData   <= skid_data;
        oRd       <= skid_rd;
        oMisalign <= skid_mis;
      end else begin
        oRdData   <= al_data;
        oRd       <= m_rd;
        oMisalign <= al_mis;
      end
    end else if (!iStall) begin
      oValid <= 1'b0;
    end
  end

endmodule
